// File: rtl/dsha256_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : dsha256_engine_if
//  Description : Block-in / digest-out stream bundle for dsha256_engine.
//                With DSHA256_MIDSTATE_EN defined it also carries the
//                mid_valid / midstate preload pair.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dsha256_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_block;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_digest;
    logic         busy;
`ifdef DSHA256_MIDSTATE_EN
    logic         mid_valid;
    logic [255:0] midstate;

    modport master (
        output in_valid, in_block, in_last, out_ready, mid_valid, midstate,
        input  in_ready, out_valid, out_digest, busy
    );
    modport slave (
        input  in_valid, in_block, in_last, out_ready, mid_valid, midstate,
        output in_ready, out_valid, out_digest, busy
    );
`else
    modport master (
        output in_valid, in_block, in_last, out_ready,
        input  in_ready, out_valid, out_digest, busy
    );
    modport slave (
        input  in_valid, in_block, in_last, out_ready,
        output in_ready, out_valid, out_digest, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/dsha256_engine.sv
`default_nettype none
// ============================================================================
//  Module      : dsha256_engine
//  Description : Iterative SHA-256 compression engine. Chains any number of
//                pre-padded 512-bit blocks, optionally re-hashes the digest
//                (DOUBLE=1) and evaluates UNROLL rounds per clock (1, 2, 4).
//                Optional macro DSHA256_MIDSTATE_EN adds a midstate preload
//                for the first block of a message.
//  Revision    : 1.0 - initial release
// ============================================================================
module dsha256_engine #(
    parameter int DOUBLE = 1,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    dsha256_engine_if.slave bus
);
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
        $error("dsha256_engine: UNROLL must be 1, 2 or 4");
    end

    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_round    = 3'd1;
    localparam logic [2:0] c_add      = 3'd2;
    localparam logic [2:0] c_wait_blk = 3'd3;
    localparam logic [2:0] c_done     = 3'd4;

    localparam logic [5:0]   c_step     = 6'(UNROLL);
    localparam logic [5:0]   c_last_cnt = 6'(64 - UNROLL);
    localparam logic [255:0] c_iv = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    // Padding tail for re-hashing a 256-bit digest (message length 256 bits)
    localparam logic [255:0] c_pad = {32'h80000000, 192'd0, 32'h00000100};
    localparam logic [31:0]  c_k [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] f_rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] f_bsig0(input logic [31:0] x);
        return f_rotr(x, 2) ^ f_rotr(x, 13) ^ f_rotr(x, 22);
    endfunction
    function automatic logic [31:0] f_bsig1(input logic [31:0] x);
        return f_rotr(x, 6) ^ f_rotr(x, 11) ^ f_rotr(x, 25);
    endfunction
    function automatic logic [31:0] f_ssig0(input logic [31:0] x);
        return f_rotr(x, 7) ^ f_rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] f_ssig1(input logic [31:0] x);
        return f_rotr(x, 17) ^ f_rotr(x, 19) ^ (x >> 10);
    endfunction

    logic [2:0]   r_state, w_state_next;
    logic [5:0]   r_cnt;
    logic [255:0] r_h;          // chaining registers H0..H7
    logic [255:0] r_v;          // working variables a..h, a in the top word
    logic [511:0] r_w;          // 16-word schedule window, oldest word on top
    logic         r_last;
    logic         r_second;
    logic [31:0]  w_sched [0:UNROLL+15];
    logic [255:0] w_vars;
    logic [511:0] w_w_next;
    logic [255:0] w_h_sum;
    logic [255:0] w_init;
    logic [31:0]  w_t1, w_t2;

`ifdef DSHA256_MIDSTATE_EN
    assign w_init = bus.mid_valid ? bus.midstate : c_iv;
`else
    assign w_init = c_iv;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= c_idle;
        else      r_state <= w_state_next;
    end

    // Next-state decision
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:     if (bus.in_valid) w_state_next = c_round;
            c_round:    if (r_cnt == c_last_cnt) w_state_next = c_add;
            c_add: begin
                if (!r_last)                          w_state_next = c_wait_blk;
                else if (DOUBLE != 0 && !r_second)    w_state_next = c_round;
                else                                  w_state_next = c_done;
            end
            c_wait_blk: if (bus.in_valid) w_state_next = c_round;
            c_done:     if (bus.out_ready) w_state_next = c_idle;
            default:    w_state_next = c_idle;
        endcase
    end

    // Handshake and status outputs; digest is only exposed while presented
    always_comb begin
        bus.in_ready   = (r_state == c_idle) || (r_state == c_wait_blk);
        bus.out_valid  = (r_state == c_done);
        bus.busy       = (r_state != c_idle);
        bus.out_digest = (r_state == c_done) ? r_h : '0;
    end

    // UNROLL chained rounds with the rolling message schedule
    always_comb begin
        w_vars   = r_v;
        w_t1     = '0;
        w_t2     = '0;
        w_w_next = '0;
        for (int i = 0; i < 16; i++) w_sched[i] = r_w[511 - 32*i -: 32];
        for (int j = 0; j < UNROLL; j++) begin
            w_sched[16 + j] = f_ssig1(w_sched[14 + j]) + w_sched[9 + j]
                            + f_ssig0(w_sched[1 + j]) + w_sched[j];
            w_t1 = w_vars[31:0] + f_bsig1(w_vars[127:96])
                 + ((w_vars[127:96] & w_vars[95:64]) ^ (~w_vars[127:96] & w_vars[63:32]))
                 + c_k[r_cnt + 6'(j)] + w_sched[j];
            w_t2 = f_bsig0(w_vars[255:224])
                 + ((w_vars[255:224] & w_vars[223:192]) ^ (w_vars[255:224] & w_vars[191:160])
                    ^ (w_vars[223:192] & w_vars[191:160]));
            w_vars = {w_t1 + w_t2, w_vars[255:160], w_vars[159:128] + w_t1, w_vars[127:32]};
        end
        for (int i = 0; i < 16; i++) w_w_next[511 - 32*i -: 32] = w_sched[UNROLL + i];
    end

    // Lane-wise feed-forward addition H[i] + var[i]
    always_comb begin
        w_h_sum = '0;
        for (int i = 0; i < 8; i++)
            w_h_sum[255 - 32*i -: 32] = r_h[255 - 32*i -: 32] + r_v[255 - 32*i -: 32];
    end

    // Datapath: block load, round update, feed-forward and second-pass setup
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_h      <= c_iv;
            r_v      <= c_iv;
            r_w      <= '0;
            r_last   <= 1'b0;
            r_second <= 1'b0;
        end else begin
            case (r_state)
                c_idle: if (bus.in_valid) begin
                    r_w      <= bus.in_block;
                    r_h      <= w_init;
                    r_v      <= w_init;
                    r_last   <= bus.in_last;
                    r_second <= 1'b0;
                    r_cnt    <= '0;
                end
                c_wait_blk: if (bus.in_valid) begin
                    r_w    <= bus.in_block;
                    r_v    <= r_h;
                    r_last <= bus.in_last;
                    r_cnt  <= '0;
                end
                c_round: begin
                    r_v   <= w_vars;
                    r_w   <= w_w_next;
                    r_cnt <= r_cnt + c_step;
                end
                c_add: begin
                    if (r_last && DOUBLE != 0 && !r_second) begin
                        r_h      <= c_iv;
                        r_v      <= c_iv;
                        r_w      <= {w_h_sum, c_pad};
                        r_second <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_h <= w_h_sum;
                    end
                end
                c_done: if (bus.out_ready) r_h <= c_iv;
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dsha256_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dsha256_engine
//  Description : Self-checking bench for dsha256_engine. Three instances
//                (DOUBLE/UNROLL = 0/1, 1/1, 1/4) are checked against a
//                straightforward array-based SHA-256 reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dsha256_engine;
    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    logic [2:0]   dv;
    logic [2:0]   dlast;
    logic [2:0]   drdy;
    logic [2:0]   dmv;
    logic [511:0] dblk [3];
    logic [255:0] dms  [3];
    wire  [2:0]   ov, ir, bz;
    wire  [255:0] od [3];

    logic [511:0] msg [$];

    logic [255:0] iv = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    logic [511:0] abc_blk = {32'h61626380, 448'd0, 32'h00000018};
    logic [511:0] gen_b1  = {32'h01000000, 256'd0, 32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e,
                             32'h67768f61, 32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa};
    logic [511:0] gen_b2  = {32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c,
                             32'h80000000, 320'd0, 32'h00000280};
    logic [255:0] abc_single = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    logic [255:0] abc_double = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
    logic [255:0] gen_double = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

    logic [31:0] kt [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    for (genvar k = 0; k < 3; k++) begin : g_dut
        dsha256_engine_if b ();
        dsha256_engine #(.DOUBLE((k == 0) ? 0 : 1), .UNROLL((k == 2) ? 4 : 1)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (b)
        );
        assign b.in_valid  = dv[k];
        assign b.in_block  = dblk[k];
        assign b.in_last   = dlast[k];
        assign b.out_ready = drdy[k];
`ifdef DSHA256_MIDSTATE_EN
        assign b.mid_valid = dmv[k];
        assign b.midstate  = dms[k];
`endif
        assign ov[k] = b.out_valid;
        assign ir[k] = b.in_ready;
        assign bz[k] = b.busy;
        assign od[k] = b.out_digest;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model (plain FIPS 180-4 arithmetic) ----------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2, s0, s1;
        logic [255:0] res;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return res;
    endfunction

    function automatic logic [255:0] ref_digest(input int dbl, input logic use_mid, input logic [255:0] mid);
        logic [255:0] h;
        h = use_mid ? mid : iv;
        foreach (msg[i]) h = ref_compress(h, msg[i]);
        if (dbl != 0) h = ref_compress(iv, {h, 32'h80000000, 192'd0, 32'h00000100});
        return h;
    endfunction

    // Drive msg into instance k (idle at a negedge on entry). Between blocks
    // the engine sits in WAIT_BLK for exactly 'stall' cycles.
    task automatic run_msg(input int k, input int stall, input logic use_mid, input logic [255:0] mid,
                           output int lat, output logic [255:0] dig);
        int t0;
        int guard;
        t0  = cyc;
        lat = -1;
        dig = '0;
        for (int b = 0; b < msg.size(); b++) begin
            if (b > 0) begin
                guard = 0;
                while (!(ir[k] && bz[k]) && guard < 300) begin @(negedge clk); guard++; end
                if (guard >= 300) begin
                    total++; bad++;
                    $display("FAIL wait_blk_timeout inst=%0d got in_ready=%0b busy=%0b need both 1", k, ir[k], bz[k]);
                    return;
                end
                repeat (stall - 1) @(negedge clk);
            end
            dv[k]    = 1'b1;
            dblk[k]  = msg[b];
            dlast[k] = (b == msg.size() - 1);
            dmv[k]   = use_mid && (b == 0);
            dms[k]   = mid;
            @(negedge clk);
            if (b == 0) t0 = cyc;
            dv[k]  = 1'b0;
            dmv[k] = 1'b0;
        end
        guard = 0;
        while (!ov[k] && guard < 2000) begin @(negedge clk); guard++; end
        if (guard >= 2000) begin
            total++; bad++;
            $display("FAIL out_valid_timeout inst=%0d got out_valid=0 need 1", k);
            return;
        end
        lat = cyc - t0;
        dig = od[k];
        if (drdy[k]) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; dv = '0; dlast = '0; drdy = 3'b111; dmv = '0;
        for (int k = 0; k < 3; k++) begin dblk[k] = '0; dms[k] = '0; end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({ir[k], ov[k], bz[k], od[k]} !== {1'b1, 1'b0, 1'b0, 256'd0}) begin
                bad++;
                $display("FAIL reset inst=%0d got ir=%0b ov=%0b busy=%0b dig=%h need 1 0 0 0", k, ir[k], ov[k], bz[k], od[k]);
            end
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abc();
        int           lat;
        logic [255:0] dig;
        int           exp_lat [3];
        exp_lat = '{65, 130, 34};
        msg = {abc_blk};
        for (int k = 0; k < 3; k++) begin
            run_msg(k, 1, 1'b0, '0, lat, dig);
            total++;
            if (dig !== ((k == 0) ? abc_single : abc_double)) begin
                bad++; $display("FAIL abc_digest inst=%0d got %h need %h", k, dig, (k == 0) ? abc_single : abc_double);
            end
            total++;
            if (dig !== ref_digest((k == 0) ? 0 : 1, 1'b0, '0)) begin
                bad++; $display("FAIL abc_model inst=%0d got %h", k, dig);
            end
            total++;
            if (lat !== exp_lat[k]) begin
                bad++; $display("FAIL abc_latency inst=%0d got %0d need %0d", k, lat, exp_lat[k]);
            end
        end
    endtask

    task automatic test_genesis();
        int           lat;
        logic [255:0] dig;
        msg = {gen_b1, gen_b2};
        run_msg(2, 5, 1'b0, '0, lat, dig);
        total++;
        if (dig !== gen_double) begin bad++; $display("FAIL genesis_digest_u4 got %h need %h", dig, gen_double); end
        total++;
        if (lat !== 56) begin bad++; $display("FAIL genesis_latency_u4 got %0d need 56", lat); end
        run_msg(1, 1, 1'b0, '0, lat, dig);
        total++;
        if (dig !== gen_double) begin bad++; $display("FAIL genesis_digest_u1 got %h need %h", dig, gen_double); end
        total++;
        if (lat !== 196) begin bad++; $display("FAIL genesis_latency_u1 got %0d need 196", lat); end
    endtask

    task automatic test_backpressure();
        int           lat;
        logic [255:0] dig;
        msg = {abc_blk};
        drdy[0] = 1'b0;
        run_msg(0, 1, 1'b0, '0, lat, dig);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({ov[0], ir[0], od[0]} !== {1'b1, 1'b0, abc_single}) begin
                bad++;
                $display("FAIL hold cycle=%0d got ov=%0b ir=%0b dig=%h need 1 0 %h", i, ov[0], ir[0], od[0], abc_single);
            end
        end
        drdy[0] = 1'b1;
        @(negedge clk);
        total++;
        if ({ir[0], ov[0], bz[0]} !== 3'b100) begin
            bad++; $display("FAIL release got ir=%0b ov=%0b busy=%0b need 1 0 0", ir[0], ov[0], bz[0]);
        end
    endtask

    task automatic test_reset_mid();
        int           lat;
        logic [255:0] dig;
        dv[0] = 1'b1; dblk[0] = abc_blk; dlast[0] = 1'b1;
        @(negedge clk);
        dv[0] = 1'b0;
        repeat (30) @(negedge clk);
        total++;
        if (bz[0] !== 1'b1) begin bad++; $display("FAIL mid_busy got %0b need 1", bz[0]); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        total++;
        if ({ir[0], ov[0], bz[0], od[0]} !== {1'b1, 1'b0, 1'b0, 256'd0}) begin
            bad++; $display("FAIL mid_reset got ir=%0b ov=%0b busy=%0b dig=%h need 1 0 0 0", ir[0], ov[0], bz[0], od[0]);
        end
        repeat (3) @(negedge clk);
        total++;
        if (ov[0] !== 1'b0) begin bad++; $display("FAIL mid_no_partial got ov=%0b need 0", ov[0]); end
        msg = {abc_blk};
        run_msg(0, 1, 1'b0, '0, lat, dig);
        total++;
        if (dig !== abc_single) begin bad++; $display("FAIL after_reset_digest got %h need %h", dig, abc_single); end
    endtask

    task automatic test_random();
        int           lat, k, n, st, dbl, u, exp_lat;
        logic         use_mid;
        logic [255:0] mid, dig, exp_dig;
        logic [511:0] blk;
        for (int it = 0; it < 8; it++) begin
            k  = $urandom_range(0, 2);
            n  = $urandom_range(1, 3);
            st = $urandom_range(1, 4);
            use_mid = 1'b0;
            mid = '0;
`ifdef DSHA256_MIDSTATE_EN
            use_mid = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) mid[255 - 32*i -: 32] = $urandom();
`endif
            msg.delete();
            for (int b = 0; b < n; b++) begin
                for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = $urandom();
                msg.push_back(blk);
            end
            dbl = (k == 0) ? 0 : 1;
            u   = (k == 2) ? 4 : 1;
            exp_dig = ref_digest(dbl, use_mid, mid);
            exp_lat = (n + dbl) * (64 / u + 1) + (n - 1) * st;
            run_msg(k, st, use_mid, mid, lat, dig);
            total++;
            if (dig !== exp_dig) begin
                bad++; $display("FAIL rand_digest it=%0d inst=%0d got %h need %h", it, k, dig, exp_dig);
            end
            total++;
            if (lat !== exp_lat) begin
                bad++; $display("FAIL rand_latency it=%0d inst=%0d got %0d need %0d", it, k, lat, exp_lat);
            end
        end
    endtask

`ifdef DSHA256_MIDSTATE_EN
    task automatic test_midstate();
        int           lat;
        logic [255:0] dig, mid;
        mid = ref_compress(iv, gen_b1);
        msg = {gen_b2};
        run_msg(2, 1, 1'b1, mid, lat, dig);
        total++;
        if (dig !== gen_double) begin bad++; $display("FAIL midstate_digest got %h need %h", dig, gen_double); end
        total++;
        if (lat !== 34) begin bad++; $display("FAIL midstate_latency got %0d need 34", lat); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        test_reset();
        test_abc();
        test_genesis();
        test_backpressure();
        test_reset_mid();
`ifdef DSHA256_MIDSTATE_EN
        test_midstate();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
